// File: rtl/aes256_pkg.sv
// Shared constants and types for the AES256 ingress front end.
package aes256_pkg;

    localparam int BLOCK_W = 128;

    localparam logic [1:0] MODE_ENC    = 2'b00;
    localparam logic [1:0] MODE_DEC    = 2'b01;
    localparam logic [1:0] MODE_KEYGEN = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ingress_state_e;

endpackage

// File: rtl/aes256_blk_fifo.sv
// Synchronous show-ahead block FIFO; extra pointer MSB distinguishes full from empty.
module aes256_blk_fifo
    import aes256_pkg::*;
#(
    parameter int WIDTH = BLOCK_W + 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/aes256_axis_ingress.sv
// AXI-Stream ingress: packs 4 words per block, queues blocks, and issues them one at a time to the AES256 core.
module aes256_axis_ingress
    import aes256_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    input  logic [1:0]         s_tuser,
    output logic [BLOCK_W-1:0] dev_inp,
    output logic               dev_ctrl_dataIn,
    output logic [1:0]         dev_mod_en,
    input  logic               dev_ctrl_dataOut,
    input  logic               err_clr,
    output logic               busy,
    output logic               err_frame,
    output logic               timeout
);

    localparam int WCW    = $clog2(TIMEOUT_CYC) + 1;
    localparam int PACK_W = BLOCK_W - 32;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = {{(WCW-1){1'b0}}, 1'b1};

    logic [1:0]         wordCnt_q, wordCnt_d;
    logic [PACK_W-1:0]  blk_q, blk_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         curMode;
    ingress_state_e     state_q, state_d;
    logic [WCW-1:0]     waitCnt_q, waitCnt_d;
    logic [BLOCK_W-1:0] devInp_q, devInp_d;
    logic [1:0]         devMode_q, devMode_d;
    logic               errFrame_q, errFrame_d;
    logic               timeout_q, timeout_d;
    logic               wordHs, fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic               setFrameErr, setTimeout;
    logic [BLOCK_W+1:0] fifoHead;

    assign s_tready = (wordCnt_q != 2'd3) || !fifoFull;
    assign wordHs   = s_tvalid && s_tready;
    assign curMode  = (wordCnt_q == 2'd0) ? s_tuser : mode_q;

    // Word 3 is never stored; it goes straight into the FIFO with the three packed words.
    always_comb begin
        wordCnt_d   = wordCnt_q;
        blk_d       = blk_q;
        mode_d      = mode_q;
        fifoPush    = 1'b0;
        setFrameErr = 1'b0;
        if (wordHs) begin
            mode_d    = curMode;
            wordCnt_d = wordCnt_q + 2'd1;
            case (wordCnt_q)
                2'd0:    blk_d[PACK_W-1  -: 32] = s_tdata;
                2'd1:    blk_d[PACK_W-33 -: 32] = s_tdata;
                2'd2:    blk_d[PACK_W-65 -: 32] = s_tdata;
                default: begin
                    if (curMode == MODE_RSVD) setFrameErr = 1'b1;
                    else                      fifoPush    = 1'b1;
                end
            endcase
            if (s_tlast && (wordCnt_q != 2'd3)) begin
                wordCnt_d   = 2'd0;
                setFrameErr = 1'b1;
            end
        end
    end

    aes256_blk_fifo #(
        .WIDTH (BLOCK_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (fifoPush),
        .wdata_i ({curMode, blk_q, s_tdata}),
        .pop_i   (fifoPop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Device outputs load on entry to ISSUE so they are already valid alongside the strobe.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        devInp_d   = devInp_q;
        devMode_d  = devMode_q;
        fifoPop    = 1'b0;
        setTimeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    state_d   = ISSUE;
                    devInp_d  = fifoHead[BLOCK_W-1:0];
                    devMode_d = fifoHead[BLOCK_W+1 -: 2];
                end
            end
            ISSUE: begin
                fifoPop   = 1'b1;
                waitCnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (dev_ctrl_dataOut) begin
                    state_d = IDLE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d    = IDLE;
                    setTimeout = 1'b1;
                end else if (waitCnt_q != '1) begin
                    waitCnt_d = waitCnt_q + WAIT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign errFrame_d = (errFrame_q && !err_clr) || setFrameErr;
    assign timeout_d  = (timeout_q && !err_clr) || setTimeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wordCnt_q  <= 2'd0;
            blk_q      <= '0;
            mode_q     <= MODE_ENC;
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            devInp_q   <= '0;
            devMode_q  <= 2'd0;
            errFrame_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wordCnt_q  <= wordCnt_d;
            blk_q      <= blk_d;
            mode_q     <= mode_d;
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            devInp_q   <= devInp_d;
            devMode_q  <= devMode_d;
            errFrame_q <= errFrame_d;
            timeout_q  <= timeout_d;
        end
    end

    assign dev_inp         = devInp_q;
    assign dev_mod_en      = devMode_q;
    assign dev_ctrl_dataIn = (state_q == ISSUE);
    assign busy            = (state_q != IDLE) || !fifoEmpty || (wordCnt_q != 2'd0);
    assign err_frame       = errFrame_q;
    assign timeout         = timeout_q;

endmodule
